pcie_cplr_asm: RTL and testbench
================================

Name: pcie_cplr_asm

Overview:
- Completer-completion assembler in the user_clk domain, directly upstream of the CC FIFO/AXIS stage.
- Accepts one MRd completion request at a time and reads the requested DWs from the local register space through a fixed-latency read port.
- Packs a Gen3 CC descriptor plus payload into 128-bit beats, each with a 16-bit sideband word, on the cc_cplr_* write interface.

Parameters:
- MAX_DW, 8, largest payload in DWs per completion; legal 1..32.
- AW, 12, byte-address width of the register space.

Ports:
- user_clk  in  1  block clock.
- user_rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  completion request valid.
- req_ready  out  1  request accepted when req_valid & req_ready.
- req_addr  in  AW  request byte address; bits [1:0] ignored.
- req_len  in  11  request length in DWs.
- req_fbe  in  4  first DW byte enables.
- req_lbe  in  4  last DW byte enables.
- req_rid  in  16  requester ID.
- req_tag  in  8  tag.
- req_tc  in  3  traffic class.
- req_attr  in  3  attributes.
- req_ur  in  1  unsupported request; used only with CPLR_UR_EN.
- rd_en  out  1  register read strobe.
- rd_addr  out  AW-2  DW address.
- rd_data  in  32  read data, valid exactly 1 cycle after rd_en.
- cc_cplr_data  out  128  beat data.
- cc_cplr_data_ex  out  16  sideband: [15] SOP, [14] EOP, [13] ERR, [12:8] valid-DW count, [7:4] FBE, [3:0] LBE.
- cc_cplr_wen  out  1  beat write strobe.
- cc_cplr_ready  in  1  downstream FIFO has room for at least 16 beats (registered downstream).

Behaviour:
- Reset values: all outputs 0; state IDLE.
- States and transitions:
  - IDLE: req_ready is registered, set to 1 when state=IDLE & cc_cplr_ready, else 0. On acceptance, latch all request fields, drop req_ready next cycle, go to RD.
  - RD: issue rd_en on consecutive cycles, incrementing rd_addr from req_addr[AW-1:2], for the DWs of the current beat (beat 0: 1 DW; later beats: min(4, remaining)). Capture rd_data 1 cycle after each rd_en into a DW shift register. Go to WR after the last DW of the beat is captured.
  - WR: assert cc_cplr_wen for 1 cycle. If DWs remain, return to RD; otherwise go to IDLE.
- cc_cplr_ready is sampled only at acceptance; once started, a packet is written to completion with no stall. This is safe because at most ceil((3+MAX_DW)/4) ≤ 9 beats are written, plus 2 in-flight, against 16 guaranteed slots.
- Beat 0 layout:
  - [6:0] lower address = {req_addr[6:2], lo}; lo = index of the lowest set bit of req_fbe, 00 if req_fbe=0.
  - [9:8] = 0; [28:16] byte count; [29] = 0.
  - [42:32] DW count = req_len; [45:43] status; [46] = 0.
  - [63:48] req_rid; [71:64] req_tag; [87:72] = 0; [88] = 0.
  - [91:89] req_tc; [94:92] req_attr; [95] = 0; [127:96] data DW0.
- Later beats: DW n in bits [32n+31:32n]; unused DWs are 0.
- Byte count:
  - len=1: span from the lowest to the highest set bit of req_fbe; 1 if req_fbe=0.
  - len>1: 4·len − (trailing zeros of req_fbe) − (leading zeros of req_lbe).
- Sideband:
  - SOP on beat 0 only; EOP on the last beat; SOP and EOP both set for a single-beat packet.
  - Valid-DW count per beat covers descriptor plus data DWs (beat 0 = 3 + data DW count).
  - FBE/LBE = request enables on beat 0, 0 on other beats.
  - ERR always 0.
- Length out of range (req_len=0 or >MAX_DW): no reads; one descriptor-only beat with SOP=EOP=1, status 3'b100 (CA), DW count 0, byte count as computed with len treated as 1, valid-DW count 3.
- Reset asserted mid-packet: abort immediately and return to IDLE with outputs 0. A partial packet may already sit in the downstream FIFO; that FIFO is reset with the pcie side.

Optional Feature:
- CPLR_UR_EN defined: an accepted request with req_ur=1 issues no reads and produces one descriptor-only beat with status 3'b001 (UR), DW count 0, lower address 0, SOP=EOP=1. UR takes precedence over the CA range check.
- CPLR_UR_EN undefined: req_ur is ignored, and every request is completed SC or CA.

Decomposition:
- Package pcie_cplr_pkg:
  - sideband bit positions (SOP=15, EOP=14, ERR=13, KEEP 12:8, FBE 7:4, LBE 3:0);
  - completion status codes (SC=0, UR=1, CA=4);
  - descriptor field offsets;
  - state enumeration.
- One combinational sub-module, pcie_cplr_bc_calc: computes lower address [1:0] and byte count from len, fbe, lbe.

Test Plan:
- 1DW read, addr=0x104, fbe=4'b0110, tag=0x5A, rd_data=0xDEADBEEF -> single beat, SOP=EOP=1, lower address=0x05, byte count=2, DW count=1, [127:96]=0xDEADBEEF, valid-DW count=4.
- len=6, addr=0x200, fbe=4'hF, lbe=4'h3 -> 3 beats carrying 1+4+1 data DWs, byte count=22, EOP only on beat 2, rd_addr runs 0x80..0x85, beat 2 valid-DW count=1.
- cc_cplr_ready=0 at request time -> req_ready stays 0 and no rd_en; ready rises -> req_ready=1 the next cycle and the packet completes normally.
- req_len=MAX_DW+1 -> no rd_en; one beat with status=3'b100, DW count=0.
- With CPLR_UR_EN defined, req_ur=1, len=4 -> one beat with status=3'b001, no rd_en; the same stimulus without the macro -> 4 reads and an SC completion.
- user_rst asserted during beat 1 of a len=8 packet -> next cycle cc_cplr_wen=0, rd_en=0, state IDLE; after reset release a fresh request completes correctly.

Source files
------------

// File: rtl/pcie_cplr_pkg.sv
// Shared constants for the completer-completion assembler: sideband bit
// positions, completion status codes, descriptor field offsets and FSM states.
package pcie_cplr_pkg;

  localparam int SB_SOP      = 15;
  localparam int SB_EOP      = 14;
  localparam int SB_ERR      = 13;
  localparam int SB_KEEP_LSB = 8;
  localparam int SB_FBE_LSB  = 4;
  localparam int SB_LBE_LSB  = 0;

  localparam logic [2:0] CPL_SC = 3'b000;
  localparam logic [2:0] CPL_UR = 3'b001;
  localparam logic [2:0] CPL_CA = 3'b100;

  localparam int D_LADDR  = 0;
  localparam int D_BC     = 16;
  localparam int D_DWCNT  = 32;
  localparam int D_STATUS = 43;
  localparam int D_RID    = 48;
  localparam int D_TAG    = 64;
  localparam int D_TC     = 89;
  localparam int D_ATTR   = 92;
  localparam int D_DATA0  = 96;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RD   = 2'd1;
  localparam logic [1:0] ST_WR   = 2'd2;

endpackage

// File: rtl/pcie_cplr_bc_calc.sv
// Byte count and lower-address [1:0] for a completion, derived from the
// request length and first/last byte enables.
module pcie_cplr_bc_calc (
  input  logic [10:0] len,
  input  logic [3:0]  fbe,
  input  logic [3:0]  lbe,
  output logic [1:0]  lo,
  output logic [12:0] bc
);

  logic [1:0] hi;
  logic [1:0] lz;

  always_comb begin
    lo = 2'd0;
    hi = 2'd0;
    lz = 2'd0;
    for (int i = 3; i >= 0; i--) if (fbe[i]) lo = 2'(i);
    for (int i = 0; i < 4; i++) if (fbe[i]) hi = 2'(i);
    for (int i = 0; i < 4; i++) if (lbe[i]) lz = 2'(3 - i);
    // trailing zeros of fbe coincide with the lowest enabled byte index
    if (len == 11'd1)
      bc = (fbe == 4'd0) ? 13'd1 : 13'(hi) - 13'(lo) + 13'd1;
    else
      bc = {len, 2'b00} - 13'(lo) - 13'(lz);
  end

endmodule

// File: rtl/pcie_cplr_asm.sv
// Completer-completion assembler: reads MRd payload DWs from the register
// space and packs descriptor plus data into 128-bit CC beats. Macro CPLR_UR_EN.
// Handshake: a request transfers on the clock edge where req_valid & req_ready.
module pcie_cplr_asm
  import pcie_cplr_pkg::*;
#(
  parameter int MAX_DW = 8,
  parameter int AW     = 12
) (
  input  logic          user_clk,
  input  logic          user_rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [AW-1:0] req_addr,
  input  logic [10:0]   req_len,
  input  logic [3:0]    req_fbe,
  input  logic [3:0]    req_lbe,
  input  logic [15:0]   req_rid,
  input  logic [7:0]    req_tag,
  input  logic [2:0]    req_tc,
  input  logic [2:0]    req_attr,
  input  logic          req_ur,
  output logic          rd_en,
  output logic [AW-3:0] rd_addr,
  input  logic [31:0]   rd_data,
  output logic [127:0]  cc_cplr_data,
  output logic [15:0]   cc_cplr_data_ex,
  output logic          cc_cplr_wen,
  input  logic          cc_cplr_ready,
  output logic [1:0]    state
);

  logic [AW-3:0]   addr_ptr;
  logic [4:0]      laddr_hi;
  logic            la_zero;
  logic [10:0]     bc_len;
  logic [10:0]     dwcnt;
  logic [3:0]      fbe, lbe;
  logic [15:0]     rid;
  logic [7:0]      tag;
  logic [2:0]      tc, attr, status;
  logic [5:0]      rem;
  logic [2:0]      beat_n, iss, cap;
  logic            cap_pend, first;
  logic [3:0][31:0] dsr;

  logic            range_err, ur_hit, unused_ok;
  logic [1:0]      lo;
  logic [12:0]     bc;
  logic [95:0]     desc;
  logic [127:0]    beat;
  logic [15:0]     sb;

  assign range_err = (req_len == 11'd0) || (req_len > 11'(MAX_DW));
`ifdef CPLR_UR_EN
  assign ur_hit = req_ur;
`else
  assign ur_hit = 1'b0;
`endif
  assign unused_ok = ^{req_addr[1:0], req_ur};

  pcie_cplr_bc_calc u_bc (
    .len (bc_len),
    .fbe (fbe),
    .lbe (lbe),
    .lo  (lo),
    .bc  (bc)
  );

  always_comb begin
    desc = '0;
    desc[D_LADDR  +: 7]  = la_zero ? 7'd0 : {laddr_hi, lo};
    desc[D_BC     +: 13] = bc;
    desc[D_DWCNT  +: 11] = dwcnt;
    desc[D_STATUS +: 3]  = status;
    desc[D_RID    +: 16] = rid;
    desc[D_TAG    +: 8]  = tag;
    desc[D_TC     +: 3]  = tc;
    desc[D_ATTR   +: 3]  = attr;
    beat = first ? {dsr[0], desc} : dsr;
    sb = '0;
    sb[SB_SOP] = first;
    sb[SB_EOP] = (rem == 6'd0);
    sb[SB_KEEP_LSB +: 5] = first ? 5'(beat_n) + 5'd3 : 5'(beat_n);
    sb[SB_FBE_LSB  +: 4] = first ? fbe : 4'd0;
    sb[SB_LBE_LSB  +: 4] = first ? lbe : 4'd0;
  end

  always_ff @(posedge user_clk or posedge user_rst) begin
    if (user_rst) begin
      state <= ST_IDLE;
      req_ready <= 1'b0;
      rd_en <= 1'b0;
      rd_addr <= '0;
      cc_cplr_data <= '0;
      cc_cplr_data_ex <= '0;
      cc_cplr_wen <= 1'b0;
      addr_ptr <= '0;
      laddr_hi <= '0;
      la_zero <= 1'b0;
      bc_len <= '0;
      dwcnt <= '0;
      fbe <= '0;
      lbe <= '0;
      rid <= '0;
      tag <= '0;
      tc <= '0;
      attr <= '0;
      status <= '0;
      rem <= '0;
      beat_n <= '0;
      iss <= '0;
      cap <= '0;
      cap_pend <= 1'b0;
      first <= 1'b0;
      dsr <= '0;
    end else begin
      cc_cplr_wen <= 1'b0;
      rd_en <= 1'b0;
      req_ready <= 1'b0;
      cap_pend <= rd_en;
      case (state)
        ST_IDLE: begin
          if (req_valid && req_ready) begin
            addr_ptr <= req_addr[AW-1:2];
            laddr_hi <= req_addr[6:2];
            la_zero <= ur_hit;
            fbe <= req_fbe;
            lbe <= req_lbe;
            rid <= req_rid;
            tag <= req_tag;
            tc <= req_tc;
            attr <= req_attr;
            first <= 1'b1;
            dsr <= '0;
            iss <= '0;
            cap <= '0;
            if (ur_hit || range_err) begin
              // descriptor-only completion: no register reads at all
              status <= ur_hit ? CPL_UR : CPL_CA;
              bc_len <= 11'd1;
              dwcnt <= '0;
              rem <= '0;
              beat_n <= '0;
              state <= ST_WR;
            end else begin
              status <= CPL_SC;
              bc_len <= req_len;
              dwcnt <= req_len;
              rem <= req_len[5:0];
              beat_n <= 3'd1;
              state <= ST_RD;
            end
          end else begin
            req_ready <= cc_cplr_ready;
          end
        end
        ST_RD: begin
          if (iss != beat_n) begin
            rd_en <= 1'b1;
            rd_addr <= addr_ptr;
            addr_ptr <= addr_ptr + 1'b1;
            iss <= iss + 3'd1;
            rem <= rem - 6'd1;
          end
          if (cap_pend) begin
            dsr[cap[1:0]] <= rd_data;
            cap <= cap + 3'd1;
            if (cap + 3'd1 == beat_n) state <= ST_WR;
          end
        end
        ST_WR: begin
          cc_cplr_wen <= 1'b1;
          cc_cplr_data <= beat;
          cc_cplr_data_ex <= sb;
          first <= 1'b0;
          dsr <= '0;
          iss <= '0;
          cap <= '0;
          if (rem != 6'd0) begin
            beat_n <= (rem > 6'd4) ? 3'd4 : rem[2:0];
            state <= ST_RD;
          end else begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pcie_cplr_asm.sv
// Self-checking bench for pcie_cplr_asm: directed cases plus random requests
// scored against a packet-level reference model. Honours CPLR_UR_EN.
module tb_pcie_cplr_asm;

  localparam int MAX_DW = 8;
  localparam int AW = 12;

  logic          user_clk = 1'b0;
  logic          user_rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [AW-1:0] req_addr = '0;
  logic [10:0]   req_len = '0;
  logic [3:0]    req_fbe = '0;
  logic [3:0]    req_lbe = '0;
  logic [15:0]   req_rid = '0;
  logic [7:0]    req_tag = '0;
  logic [2:0]    req_tc = '0;
  logic [2:0]    req_attr = '0;
  logic          req_ur = 1'b0;
  logic          rd_en;
  logic [AW-3:0] rd_addr;
  logic [31:0]   rd_data = '0;
  logic [127:0]  cc_cplr_data;
  logic [15:0]   cc_cplr_data_ex;
  logic          cc_cplr_wen;
  logic          cc_cplr_ready = 1'b1;
  logic [1:0]    state;

  logic [31:0]  mem [0:1023];
  logic [143:0] exp_q[$];
  logic [9:0]   exp_rd_q[$];
  int n_checks = 0;
  int n_fail = 0;
  int wen_cnt = 0;
  int rd_cnt = 0;

  pcie_cplr_asm #(.MAX_DW(MAX_DW), .AW(AW)) dut (
    .user_clk(user_clk), .user_rst(user_rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_len(req_len), .req_fbe(req_fbe), .req_lbe(req_lbe),
    .req_rid(req_rid), .req_tag(req_tag), .req_tc(req_tc), .req_attr(req_attr),
    .req_ur(req_ur), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .cc_cplr_data(cc_cplr_data), .cc_cplr_data_ex(cc_cplr_data_ex),
    .cc_cplr_wen(cc_cplr_wen), .cc_cplr_ready(cc_cplr_ready), .state(state)
  );

  // clock / reset
  always #5 user_clk = ~user_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // register space: data valid exactly one cycle after rd_en, junk otherwise
  always @(posedge user_clk) rd_data <= rd_en ? mem[rd_addr] : $urandom;

  task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // scoreboard monitor, sampled on the falling edge
  always @(negedge user_clk) begin
    if (!user_rst) begin
      if (rd_en) begin
        rd_cnt++;
        if (exp_rd_q.size() == 0) check("unexpected_rd", 1, 0);
        else check("rd_addr", rd_addr, exp_rd_q.pop_front());
      end
      if (cc_cplr_wen) begin
        logic [143:0] e;
        wen_cnt++;
        if (exp_q.size() == 0) check("unexpected_beat", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("beat_data", cc_cplr_data, e[127:0]);
          check("beat_sideband", cc_cplr_data_ex, e[143:128]);
        end
      end
    end
  end

  // reference model: whole-packet expectation from the current request fields
  task automatic model_push();
    logic [31:0]  dws[$];
    logic [127:0] d;
    logic [15:0]  sb;
    logic [2:0]   st;
    bit ur_hit, bad;
    int n, eff, lo, hi, lz, bc, nbeats, k, base;
    ur_hit = 1'b0;
`ifdef CPLR_UR_EN
    ur_hit = req_ur;
`endif
    bad = (req_len == 0) || (req_len > MAX_DW);
    st = ur_hit ? 3'b001 : (bad ? 3'b100 : 3'b000);
    n = (ur_hit || bad) ? 0 : int'(req_len);
    eff = (ur_hit || bad) ? 1 : int'(req_len);
    base = int'(req_addr[AW-1:2]);
    for (int i = 0; i < n; i++) begin
      dws.push_back(mem[(base + i) % 1024]);
      exp_rd_q.push_back(10'((base + i) % 1024));
    end
    lo = 0; hi = 0; lz = 0;
    if (req_fbe != 0) begin
      lo = 3; while (!req_fbe[lo]) lo--;
      for (int i = 0; i < 4; i++) if (req_fbe[i]) begin lo = i; break; end
      hi = 3; while (!req_fbe[hi]) hi--;
    end
    if (req_lbe != 0) begin
      int top = 3;
      while (!req_lbe[top]) top--;
      lz = 3 - top;
    end
    if (eff == 1) bc = (req_fbe == 0) ? 1 : hi - lo + 1;
    else bc = 4 * eff - lo - lz;
    nbeats = (n <= 1) ? 1 : 1 + (n - 1 + 3) / 4;
    d = '0;
    d[6:0] = ur_hit ? 7'd0 : {req_addr[6:2], 2'(lo)};
    d[28:16] = 13'(bc);
    d[42:32] = 11'(n);
    d[45:43] = st;
    d[63:48] = req_rid;
    d[71:64] = req_tag;
    d[91:89] = req_tc;
    d[94:92] = req_attr;
    d[127:96] = (n > 0) ? dws[0] : 32'd0;
    sb = {1'b1, nbeats == 1, 1'b0, 5'(3 + (n > 0 ? 1 : 0)), req_fbe, req_lbe};
    exp_q.push_back({sb, d});
    for (int b = 1; b < nbeats; b++) begin
      k = n - 1 - 4 * (b - 1);
      if (k > 4) k = 4;
      d = '0;
      for (int j = 0; j < k; j++) d[32*j +: 32] = dws[1 + 4 * (b - 1) + j];
      sb = {1'b0, b == nbeats - 1, 1'b0, 5'(k), 8'h00};
      exp_q.push_back({sb, d});
    end
  endtask

  // driver tasks
  task automatic set_req(input logic [11:0] a, input int len, input logic [3:0] f,
                         input logic [3:0] l, input logic [7:0] t, input logic ur);
    req_addr = a; req_len = 11'(len); req_fbe = f; req_lbe = l; req_tag = t; req_ur = ur;
    req_rid = 16'($urandom); req_tc = 3'($urandom); req_attr = 3'($urandom);
  endtask

  task automatic send_req();
    int n;
    @(negedge user_clk);
    req_valid = 1'b1;
    model_push();
    n = 0;
    while (!req_ready && n < 200) begin @(negedge user_clk); n++; end
    if (!req_ready) check("req_ready_timeout", 0, 1);
    @(negedge user_clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while ((exp_q.size() != 0 || exp_rd_q.size() != 0) && n < 2000) begin
      @(negedge user_clk); n++;
    end
    if (exp_q.size() != 0 || exp_rd_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
    repeat (3) @(negedge user_clk);
  endtask

  initial begin
    int rd0, wen0, n;
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    mem[10'h041] = 32'hDEADBEEF;

    repeat (3) @(negedge user_clk);
    check("rst_req_ready", req_ready, 0);
    check("rst_rd_en", rd_en, 0);
    check("rst_rd_addr", rd_addr, 0);
    check("rst_wen", cc_cplr_wen, 0);
    check("rst_data", cc_cplr_data, 0);
    check("rst_data_ex", cc_cplr_data_ex, 0);
    check("rst_state", state, 0);
    user_rst = 1'b0;
    repeat (2) @(negedge user_clk);

    // single-DW read
    wen0 = wen_cnt;
    set_req(12'h104, 1, 4'b0110, 4'b0000, 8'h5A, 1'b0);
    send_req();
    wait_done();
    check("one_dw_beats", wen_cnt - wen0, 1);

    // three-beat packet
    wen0 = wen_cnt; rd0 = rd_cnt;
    set_req(12'h200, 6, 4'hF, 4'h3, 8'h11, 1'b0);
    send_req();
    wait_done();
    check("len6_beats", wen_cnt - wen0, 3);
    check("len6_reads", rd_cnt - rd0, 6);

    // downstream not ready: request must be held off
    @(negedge user_clk);
    cc_cplr_ready = 1'b0;
    repeat (2) @(negedge user_clk);
    rd0 = rd_cnt;
    set_req(12'h310, 3, 4'hC, 4'h7, 8'h22, 1'b0);
    req_valid = 1'b1;
    model_push();
    for (int i = 0; i < 6; i++) begin
      @(negedge user_clk);
      check("ready_held_low", req_ready, 0);
    end
    check("no_rd_while_blocked", rd_cnt, rd0);
    cc_cplr_ready = 1'b1;
    @(negedge user_clk);
    check("ready_rise", req_ready, 1);
    @(negedge user_clk);
    req_valid = 1'b0;
    wait_done();

    // length out of range -> CA, no reads
    wen0 = wen_cnt; rd0 = rd_cnt;
    set_req(12'h048, MAX_DW + 1, 4'hF, 4'hF, 8'h33, 1'b0);
    send_req();
    wait_done();
    check("ca_reads", rd_cnt - rd0, 0);
    check("ca_beats", wen_cnt - wen0, 1);

    // unsupported-request flag
    rd0 = rd_cnt;
    set_req(12'h080, 4, 4'hF, 4'hF, 8'h44, 1'b1);
    send_req();
    wait_done();
`ifdef CPLR_UR_EN
    check("ur_reads", rd_cnt - rd0, 0);
`else
    check("ur_ignored_reads", rd_cnt - rd0, 4);
`endif

    // reset in the middle of a len=8 packet
    wen0 = wen_cnt;
    set_req(12'h400, 8, 4'hF, 4'hF, 8'h55, 1'b0);
    send_req();
    n = 0;
    while (wen_cnt == wen0 && n < 200) begin @(negedge user_clk); n++; end
    check("mid_rst_beat0_seen", wen_cnt - wen0, 1);
    repeat (2) @(negedge user_clk);
    user_rst = 1'b1;
    @(negedge user_clk);
    check("mid_rst_wen", cc_cplr_wen, 0);
    check("mid_rst_rd_en", rd_en, 0);
    check("mid_rst_state", state, 0);
    exp_q.delete();
    exp_rd_q.delete();
    @(negedge user_clk);
    user_rst = 1'b0;
    repeat (2) @(negedge user_clk);
    set_req(12'h3F8, 5, 4'h8, 4'h1, 8'h66, 1'b0);
    send_req();
    wait_done();

    // randomized requests, issued back to back
    for (int r = 0; r < 40; r++) begin
      int len;
      logic [3:0] f, l;
      len = $urandom_range(0, MAX_DW + 2);
      f = 4'($urandom);
      l = 4'($urandom);
      if (len > 1) begin
        if (f == 0) f = 4'h8;
        if (l == 0) l = 4'h1;
      end else begin
        l = 4'h0;
      end
      set_req(12'($urandom), len, f, l, 8'($urandom), ($urandom_range(0, 3) == 0));
      send_req();
    end
    wait_done();
    check("final_beats_drained", exp_q.size(), 0);
    check("final_reads_drained", exp_rd_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
